// File: rtl/psg_sequencer.sv
// Command FIFO plus replay engine driving the PSG register write bus.
// WRITE words become one-cycle wr pulses; WAIT words hold off the next pop for N ticks.
module psg_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [11:0]                 cmd,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic [7:0]                  data,
    output logic [2:0]                  address,
    output logic                        wr,
    output logic                        busy
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0] PS_PRE  = (TICK_DIV > 1) ? PS_W'(TICK_DIV - 2) : '0;
    // The pop that leaves WAIT absorbs the final prescale edge, so WAIT N spans exactly N*TICK_DIV edges.
    localparam logic [10:0] REM_EXIT = (TICK_DIV > 1) ? 11'd1 : 11'd2;
    localparam logic [10:0] N_MIN    = (TICK_DIV > 1) ? 11'd0 : 11'd1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    logic [11:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    state_t          r_state;
    logic [10:0]     r_remaining;
    logic [PS_W-1:0] r_prescale;
    logic            r_wr;
    logic [2:0]      r_address;
    logic [7:0]      r_data;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [11:0]     w_head;
    state_t          w_next_state;
    logic [10:0]     w_next_remaining;
    logic [PS_W-1:0] w_next_prescale;
    logic            w_next_wr;
    logic [2:0]      w_next_address;
    logic [7:0]      w_next_data;

    // Handshake: a word transfers on any rising edge where cmd_valid && cmd_ready.
    assign w_full    = (r_level == (AW+1)'(FIFO_DEPTH));
    assign cmd_ready = !w_full && !rst;
    assign w_push    = cmd_valid && cmd_ready;
    // Pop decision uses the registered level, so a word pushed this edge cannot leave before the next.
    assign w_pop     = (r_state == ST_IDLE) && (r_level != '0);
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_remaining = r_remaining;
        w_next_prescale  = r_prescale;
        w_next_wr        = 1'b0;
        w_next_address   = r_address;
        w_next_data      = r_data;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    if (!w_head[11]) begin
                        w_next_wr      = 1'b1;
                        w_next_address = w_head[10:8];
                        w_next_data    = w_head[7:0];
                    end else if (w_head[10:0] > N_MIN) begin
                        w_next_state     = ST_WAIT;
                        w_next_remaining = w_head[10:0];
                        w_next_prescale  = '0;
                    end
                end
            end
            ST_WAIT: begin
                if ((r_remaining == REM_EXIT) && (r_prescale == PS_PRE)) begin
                    w_next_state     = ST_IDLE;
                    w_next_remaining = '0;
                    w_next_prescale  = '0;
                end else if (r_prescale == PS_LAST) begin
                    w_next_prescale  = '0;
                    w_next_remaining = r_remaining - 11'd1;
                end else begin
                    w_next_prescale  = r_prescale + 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_prescale  <= '0;
            r_wr        <= 1'b0;
            r_address   <= '0;
            r_data      <= '0;
        end else begin
            r_state     <= w_next_state;
            r_remaining <= w_next_remaining;
            r_prescale  <= w_next_prescale;
            r_wr        <= w_next_wr;
            r_address   <= w_next_address;
            r_data      <= w_next_data;
        end
    end

    assign level   = r_level;
    assign wr      = r_wr;
    assign address = r_address;
    assign data    = r_data;
    assign busy    = (r_level != '0) || (r_state == ST_WAIT) || r_wr;

endmodule
